// File: rtl/frame_issuer_pkg.sv
// Shared CPU frame definitions: opcodes, frame field slices and issuer states.
// Imported by the frame issuer and by the CPU frame decoder.
package frame_issuer_pkg;

  localparam int FRAME_W = 17;
  localparam int PC_W    = 8;

  // Frame field slices: {opcode[16:13], operands[12:0]}
  localparam int OPC_MSB     = 16;
  localparam int OPC_LSB     = 13;
  localparam int JMP_TGT_MSB = 12;
  localparam int JMP_TGT_LSB = 5;
  localparam int CMP_A_MSB   = 12;
  localparam int CMP_A_LSB   = 9;
  localparam int CMP_B_MSB   = 8;
  localparam int CMP_B_LSB   = 5;
  localparam int BR_TGT_MSB  = 4;
  localparam int BR_TGT_LSB  = 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JNE  = 4'hD;
  localparam logic [3:0] OP_JEQ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_ISSUE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic [3:0] frame_opcode(input logic [FRAME_W-1:0] f);
    return f[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/frame_issuer_next_pc.sv
// Combinational next-PC resolver. Branch conditions compare the literal
// operand fields of the frame, never register contents.
module frame_issuer_next_pc
  import frame_issuer_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [3:0]      opcode,
  input  logic [7:0]      jmp_tgt,
  input  logic [3:0]      cmp_a,
  input  logic [3:0]      cmp_b,
  input  logic [3:0]      br_tgt,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_inc;

  // 8'hFF + 1 wraps to 8'h00 by width truncation
  assign pc_inc = pc + 8'd1;

  always_comb begin
    next_pc = pc_inc;
    case (opcode)
      OP_JMP: next_pc = jmp_tgt;
      OP_JNE: if (cmp_a != cmp_b) next_pc = {4'h0, br_tgt};
      OP_JEQ: if (cmp_a == cmp_b) next_pc = {4'h0, br_tgt};
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/frame_issuer.sv
// Program store plus fetch/issue sequencer driving the CPU frame bus.
// Handshake: a frame transfers on any sysclk edge where frame_valid && frame_ready; frame_out is held while valid.
module frame_issuer
  import frame_issuer_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic               sysclk,
  input  logic               reset_n,
  input  logic               prog_we,
  input  logic [7:0]         prog_addr,
  input  logic [16:0]        prog_data,
  input  logic               start,
  input  logic               halt_req,
  output logic [16:0]        frame_out,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               busy,
  output logic               done,
  output logic [7:0]         pc_out,
  output logic [1:0]         state_dbg
);

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [FRAME_W-1:0] ir;
  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    next_pc;
  logic               loadable;
  logic               is_halt;

  assign loadable = (state == ST_IDLE) || (state == ST_DONE);
  assign is_halt  = (frame_opcode(ir) == OP_HALT);

  // Store has no reset; ir only captures in FETCH so it holds through ISSUE stalls
  always_ff @(posedge sysclk) begin
    if (prog_we && loadable) mem[prog_addr] <= prog_data;
    if (state == ST_FETCH) ir <= mem[pc];
  end

  frame_issuer_next_pc u_next_pc (
    .pc      (pc),
    .opcode  (frame_opcode(ir)),
    .jmp_tgt (ir[JMP_TGT_MSB:JMP_TGT_LSB]),
    .cmp_a   (ir[CMP_A_MSB:CMP_A_LSB]),
    .cmp_b   (ir[CMP_B_MSB:CMP_B_LSB]),
    .br_tgt  (ir[BR_TGT_MSB:BR_TGT_LSB]),
    .next_pc (next_pc)
  );

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      pc    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_FETCH;
            pc    <= '0;
          end
        end
        ST_FETCH: state <= halt_req ? ST_DONE : ST_ISSUE;
        ST_ISSUE: begin
          if (is_halt) begin
            state <= ST_DONE;
          end else if (frame_ready) begin
            pc    <= next_pc;
            state <= halt_req ? ST_DONE : ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from state so reset drops valid without waiting for an edge
  assign frame_valid = (state == ST_ISSUE) && !is_halt;
  assign frame_out   = frame_valid ? ir : '0;
  assign busy        = (state == ST_FETCH) || (state == ST_ISSUE);
  assign done        = (state == ST_DONE);
  assign pc_out      = pc;
  assign state_dbg   = state;

endmodule

// File: tb/tb_frame_issuer.sv
// Directed bench for frame_issuer: linear, branch, backpressure, halt,
// store protection, wrap and asynchronous reset scenarios.
module tb_frame_issuer;

  logic        sysclk;
  logic        reset_n;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [16:0] prog_data;
  logic        start;
  logic        halt_req;
  logic [16:0] frame_out;
  logic        frame_valid;
  logic        frame_ready;
  logic        busy;
  logic        done;
  logic [7:0]  pc_out;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  int hs_mark;

  localparam logic [16:0] HALT_W = 17'h1E000;

  frame_issuer dut (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .halt_req    (halt_req),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .done        (done),
    .pc_out      (pc_out),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (frame_valid && frame_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [16:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for a valid frame, check it, then complete the handshake
  task automatic expect_frame(input string tag, input logic [16:0] f, input logic [7:0] p,
                              input logic hlt);
    int n = 0;
    while (!frame_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, frame_valid, 1);
    check({tag, "_frame"}, frame_out, f);
    check({tag, "_pc"}, pc_out, p);
    frame_ready = 1'b1;
    halt_req    = hlt;
    tick();
    halt_req    = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [7:0] p);
    int n = 0;
    while (!done && n < 20) begin
      check({tag, "_novalid"}, frame_valid, 0);
      tick();
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_pc"}, pc_out, p);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    start       = 1'b0;
    halt_req    = 1'b0;
    frame_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_state", state_dbg, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_frame", frame_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pc_out, 0);
    reset_n = 1'b1;
    tick();

    // Linear program, exact 2-cycle spacing
    load(8'd0, 17'h02A40);
    load(8'd1, 17'h06000);
    load(8'd2, HALT_W);
    pulse_start();
    check("lin_fetch0_state", state_dbg, 1);
    check("lin_fetch0_valid", frame_valid, 0);
    tick();
    check("lin_f0_valid", frame_valid, 1);
    check("lin_f0_frame", frame_out, 17'h02A40);
    check("lin_f0_pc", pc_out, 0);
    tick();
    check("lin_fetch1_valid", frame_valid, 0);
    check("lin_fetch1_pc", pc_out, 1);
    tick();
    check("lin_f1_valid", frame_valid, 1);
    check("lin_f1_frame", frame_out, 17'h06000);
    tick();
    check("lin_fetch2_pc", pc_out, 2);
    tick();
    check("lin_halt_valid", frame_valid, 0);
    check("lin_halt_busy", busy, 1);
    tick();
    check("lin_done", done, 1);
    check("lin_done_pc", pc_out, 2);

    // halt_req seen in FETCH ends the run without issuing
    hs_mark = hs_cnt;
    pulse_start();
    halt_req = 1'b1;
    check("hfetch_valid", frame_valid, 0);
    tick();
    halt_req = 1'b0;
    check("hfetch_done", done, 1);
    check("hfetch_pc", pc_out, 0);
    check("hfetch_hs", hs_cnt - hs_mark, 0);

    // JMP
    load(8'd0, 17'h18200);
    load(8'd16, HALT_W);
    pulse_start();
    expect_frame("jmp_f0", 17'h18200, 8'd0, 1'b0);
    expect_done("jmp_end", 8'd16);

    // Branch fall-through and taken for both JNE and JEQ
    load(8'd0, 17'h1A66A);  // JNE 3/3 -> 5: falls through
    load(8'd1, 17'h1C68A);  // JEQ 3/4 -> 5: falls through
    load(8'd2, 17'h1C66C);  // JEQ 3/3 -> 6: taken
    load(8'd6, 17'h1A692);  // JNE 3/4 -> 9: taken
    load(8'd9, HALT_W);
    pulse_start();
    expect_frame("br_jne_eq", 17'h1A66A, 8'd0, 1'b0);
    expect_frame("br_jeq_ne", 17'h1C68A, 8'd1, 1'b0);
    expect_frame("br_jeq_eq", 17'h1C66C, 8'd2, 1'b0);
    expect_frame("br_jne_ne", 17'h1A692, 8'd6, 1'b0);
    expect_done("br_end", 8'd9);

    // Backpressure: ready low for 4 cycles
    load(8'd0, 17'h00123);
    load(8'd1, HALT_W);
    frame_ready = 1'b0;
    hs_mark = hs_cnt;
    pulse_start();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", frame_valid, 1);
      check("bp_frame", frame_out, 17'h00123);
      check("bp_pc", pc_out, 0);
      tick();
    end
    frame_ready = 1'b1;
    check("bp_last_valid", frame_valid, 1);
    tick();
    check("bp_after_valid", frame_valid, 0);
    check("bp_after_pc", pc_out, 1);
    expect_done("bp_end", 8'd1);
    check("bp_hs", hs_cnt - hs_mark, 1);

    // halt_req during a stalled ISSUE
    load(8'd0, 17'h00AAA);
    load(8'd1, 17'h00BBB);
    load(8'd2, HALT_W);
    frame_ready = 1'b0;
    pulse_start();
    tick();
    halt_req = 1'b1;
    tick();
    check("hstall_valid", frame_valid, 1);
    check("hstall_frame", frame_out, 17'h00AAA);
    frame_ready = 1'b1;
    tick();
    halt_req = 1'b0;
    check("hstall_done", done, 1);
    check("hstall_pc", pc_out, 1);
    check("hstall_valid_off", frame_valid, 0);

    // prog_we while busy is ignored
    pulse_start();
    prog_we   = 1'b1;
    prog_addr = 8'd0;
    prog_data = 17'h05555;
    tick();
    tick();
    prog_we   = 1'b0;
    expect_frame("wbusy_f1", 17'h00BBB, 8'd1, 1'b0);
    expect_done("wbusy_end", 8'd2);
    pulse_start();
    expect_frame("wbusy_rerun_f0", 17'h00AAA, 8'd0, 1'b0);
    expect_frame("wbusy_rerun_f1", 17'h00BBB, 8'd1, 1'b0);
    expect_done("wbusy_rerun_end", 8'd2);

    // prog_we and start together: first fetch sees new word 0
    prog_we   = 1'b1;
    prog_addr = 8'd0;
    prog_data = 17'h00777;
    pulse_start();
    prog_we   = 1'b0;
    expect_frame("wrst_f0", 17'h00777, 8'd0, 1'b0);
    expect_frame("wrst_f1", 17'h00BBB, 8'd1, 1'b0);
    expect_done("wrst_end", 8'd2);

    // Wrap: all 256 words NOP, pc rolls from FF to 00
    for (int i = 0; i < 256; i++) load(8'(i), 17'(i));
    pulse_start();
    for (int i = 0; i < 256; i++) expect_frame("wrap_nop", 17'(i), 8'(i), 1'b0);
    expect_frame("wrap_again0", 17'h00000, 8'd0, 1'b1);
    expect_done("wrap_end", 8'd1);

    // No HALT anywhere, JMP at FF loops back to 3
    load(8'hFF, 17'h18060);
    pulse_start();
    for (int i = 0; i < 255; i++) expect_frame("loop_nop", 17'(i), 8'(i), 1'b0);
    expect_frame("loop_jmp", 17'h18060, 8'hFF, 1'b0);
    expect_frame("loop_tgt", 17'h00003, 8'd3, 1'b1);
    expect_done("loop_end", 8'd4);

    // Asynchronous reset mid-ISSUE
    load(8'd0, 17'h00321);
    frame_ready = 1'b0;
    pulse_start();
    tick();
    check("arst_pre_valid", frame_valid, 1);
    hs_mark = hs_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", frame_valid, 0);
    check("arst_state", state_dbg, 0);
    check("arst_busy", busy, 0);
    check("arst_pc", pc_out, 0);
    check("arst_frame", frame_out, 0);
    frame_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_hs", hs_cnt - hs_mark, 0);
    check("arst_idle", state_dbg, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
